// File: rtl/reg_file_pc.sv
// Multi-port register file whose top register is a program counter.
// Each register has a pending-write scoreboard bit, and writes can be forwarded to the read ports.
module reg_file_pc #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AW        = 4,
   parameter int unsigned PC_STEP   = 4,
   parameter int unsigned PC_RD_OFS = 8,
   parameter bit          BYPASS    = 1'b1
) (
   input  logic             REGCLK,
   input  logic             CLR,
   input  logic             WE,
   input  logic [AW-1:0]    WA,
   input  logic [WIDTH-1:0] WD,
   input  logic             CE,
   input  logic [AW-1:0]    CA,
   input  logic             RSV,
   input  logic [AW-1:0]    RSVA,
   input  logic             PCINC,
   input  logic [AW-1:0]    RA,
   input  logic [AW-1:0]    RB,
   input  logic [AW-1:0]    RC,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic             ABUSY,
   output logic             BBUSY,
   output logic             CBUSY,
   output logic [WIDTH-1:0] PC
);

   localparam logic [AW-1:0] PcAddr = AW'(DEPTH - 1);
   localparam int unsigned   NPorts = 3;

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;

   logic [WIDTH-1:0] w_regs_d [DEPTH];
   logic [DEPTH-1:0] w_busy_d;

   logic [AW-1:0]    w_ra    [NPorts];
   logic [WIDTH-1:0] w_rdata [NPorts];
   logic             w_rbusy [NPorts];

   function automatic logic valid_addr(input logic [AW-1:0] addr);
      return 32'(addr) < DEPTH;
   endfunction

   // Later assignments override earlier ones: CE > RSV > WE > PC increment.
   always_comb begin
      w_regs_d = r_regs;
      w_busy_d = r_busy;
      if (PCINC) begin
         w_regs_d[PcAddr] = r_regs[PcAddr] + WIDTH'(PC_STEP);
      end
      if (WE && valid_addr(WA)) begin
         w_regs_d[WA] = WD;
         w_busy_d[WA] = 1'b0;
      end
      if (RSV && valid_addr(RSVA)) begin
         w_busy_d[RSVA] = 1'b1;
      end
      if (CE && valid_addr(CA)) begin
         w_regs_d[CA] = '0;
         w_busy_d[CA] = 1'b0;
      end
   end

   always_ff @(posedge REGCLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         r_regs <= w_regs_d;
         r_busy <= w_busy_d;
      end
   end

   assign w_ra[0] = RA;
   assign w_ra[1] = RB;
   assign w_ra[2] = RC;

   // Forwarding is gated by CLR so reads stay at reset values while reset is held.
   always_comb begin
      for (int p = 0; p < int'(NPorts); p++) begin
         w_rdata[p] = '0;
         w_rbusy[p] = 1'b0;
         if (valid_addr(w_ra[p])) begin
            if (w_ra[p] == PcAddr) begin
               w_rdata[p] = r_regs[PcAddr] + WIDTH'(PC_RD_OFS);
            end else begin
               w_rdata[p] = r_regs[w_ra[p]];
            end
            w_rbusy[p] = r_busy[w_ra[p]];
            if (BYPASS && CLR && WE && (WA == w_ra[p]) && (w_ra[p] != PcAddr)) begin
               w_rdata[p] = WD;
               w_rbusy[p] = 1'b0;
            end
         end
      end
   end

   assign A     = w_rdata[0];
   assign B     = w_rdata[1];
   assign C     = w_rdata[2];
   assign ABUSY = w_rbusy[0];
   assign BBUSY = w_rbusy[1];
   assign CBUSY = w_rbusy[2];
   assign PC    = r_regs[PcAddr];

endmodule

// File: tb/tb_reg_file_pc.sv
// Directed bench for reg_file_pc: one instance with forwarding, one without, on shared inputs.
module tb_reg_file_pc;

   logic        REGCLK = 1'b0;
   logic        CLR, WE, CE, RSV, PCINC;
   logic [3:0]  WA, CA, RSVA, RA, RB, RC;
   logic [31:0] WD;
   logic [31:0] A, B, C, PC;
   logic        ABUSY, BBUSY, CBUSY;
   logic [31:0] nb_a, nb_b, nb_c, nb_pc;
   logic        nb_abusy, nb_bbusy, nb_cbusy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 REGCLK = ~REGCLK;

   reg_file_pc #(.BYPASS(1'b1)) u_dut (
      .REGCLK(REGCLK), .CLR(CLR), .WE(WE), .WA(WA), .WD(WD), .CE(CE), .CA(CA),
      .RSV(RSV), .RSVA(RSVA), .PCINC(PCINC), .RA(RA), .RB(RB), .RC(RC),
      .A(A), .B(B), .C(C), .ABUSY(ABUSY), .BBUSY(BBUSY), .CBUSY(CBUSY), .PC(PC)
   );

   reg_file_pc #(.BYPASS(1'b0)) u_nb (
      .REGCLK(REGCLK), .CLR(CLR), .WE(WE), .WA(WA), .WD(WD), .CE(CE), .CA(CA),
      .RSV(RSV), .RSVA(RSVA), .PCINC(PCINC), .RA(RA), .RB(RB), .RC(RC),
      .A(nb_a), .B(nb_b), .C(nb_c), .ABUSY(nb_abusy), .BBUSY(nb_bbusy), .CBUSY(nb_cbusy),
      .PC(nb_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge REGCLK);
      #1;
   endtask

   task automatic idle();
      WE = 1'b0; CE = 1'b0; RSV = 1'b0; PCINC = 1'b0;
   endtask

   initial begin
      CLR = 1'b0; idle();
      WA = '0; CA = '0; RSVA = '0; WD = '0;
      RA = 4'd0; RB = 4'd3; RC = 4'd15;
      #2;
      chk("rst_a", A, 32'h0);
      chk("rst_b", B, 32'h0);
      chk("rst_c_pc", C, 32'h8);
      chk("rst_pc", PC, 32'h0);
      chk("rst_busy", {29'd0, ABUSY, BBUSY, CBUSY}, 32'h0);
      #10 CLR = 1'b1;
      tick();

      // Write then read, with and without forwarding
      WE = 1'b1; WA = 4'd3; WD = 32'hDEADBEEF; RA = 4'd3;
      #1;
      chk("byp_a", A, 32'hDEADBEEF);
      chk("byp_abusy", {31'd0, ABUSY}, 32'h0);
      chk("nobyp_a", nb_a, 32'h0);
      tick();
      WE = 1'b0;
      #1;
      chk("wr_a", A, 32'hDEADBEEF);
      chk("nobyp_wr_a", nb_a, 32'hDEADBEEF);

      // PC increment and read offset
      RB = 4'd15; PCINC = 1'b1;
      #1;
      chk("pc0", PC, 32'h0);
      chk("pc0_b", B, 32'h8);
      tick();
      chk("pc1", PC, 32'h4);
      chk("pc1_b", B, 32'hC);
      tick();
      chk("pc2", PC, 32'h8);
      tick();
      chk("pc3", PC, 32'hC);
      chk("pc3_b", B, 32'h14);
      chk("pc3_nb", nb_pc, 32'hC);

      // PC write beats increment; PC index is never forwarded
      WE = 1'b1; WA = 4'd15; WD = 32'd100;
      #1;
      chk("pc_nobyp_b", B, 32'h14);
      tick();
      idle();
      #1;
      chk("pc_wr", PC, 32'h64);
      chk("pc_wr_b", B, 32'h6C);
      WE = 1'b1; WA = 4'd15; WD = 32'hFFFFFFFC;
      tick();
      idle(); PCINC = 1'b1;
      #1;
      chk("pc_max", PC, 32'hFFFFFFFC);
      chk("pc_max_b", B, 32'h4);
      tick();
      idle();
      #1;
      chk("pc_wrap", PC, 32'h0);

      // Scoreboard
      RA = 4'd5; RB = 4'd5; RSV = 1'b1; RSVA = 4'd5;
      tick();
      idle();
      #1;
      chk("rsv_abusy", {31'd0, ABUSY}, 32'h1);
      chk("rsv_bbusy", {31'd0, BBUSY}, 32'h1);
      chk("rsv_a_eq_b", A, B);
      WE = 1'b1; WA = 4'd5; WD = 32'h55;
      #1;
      chk("byp_busy_clr", {31'd0, ABUSY}, 32'h0);
      chk("nobyp_busy", {31'd0, nb_abusy}, 32'h1);
      chk("byp_a5", A, 32'h55);
      tick();
      idle();
      #1;
      chk("we_clr_busy", {31'd0, ABUSY}, 32'h0);
      chk("we_a5", A, 32'h55);
      RSV = 1'b1; RSVA = 4'd5; WE = 1'b1; WA = 4'd5; WD = 32'h66;
      tick();
      idle();
      #1;
      chk("rsv_we_busy", {31'd0, ABUSY}, 32'h1);
      chk("rsv_we_a", A, 32'h66);
      CE = 1'b1; CA = 4'd5;
      #1;
      chk("ce_pre_a", A, 32'h66);
      tick();
      idle();
      #1;
      chk("ce_a", A, 32'h0);
      chk("ce_busy", {31'd0, ABUSY}, 32'h0);
      WE = 1'b1; WA = 4'd5; WD = 32'h77; RSV = 1'b1; RSVA = 4'd5;
      tick();
      CE = 1'b1; CA = 4'd5; WD = 32'h88;
      tick();
      idle();
      #1;
      chk("ce_all_a", A, 32'h0);
      chk("ce_all_busy", {31'd0, ABUSY}, 32'h0);

      // Clear beats write
      WE = 1'b1; WA = 4'd2; WD = 32'h11; RA = 4'd2;
      tick();
      idle();
      #1;
      chk("r2_pre", A, 32'h11);
      CE = 1'b1; CA = 4'd2; WE = 1'b1; WA = 4'd2; WD = 32'h7;
      tick();
      idle();
      #1;
      chk("ce_we_r2", A, 32'h0);

      // Asynchronous reset between edges
      WE = 1'b1; WA = 4'd5; WD = 32'h55;
      tick();
      idle(); RSV = 1'b1; RSVA = 4'd6; PCINC = 1'b1;
      tick();
      idle(); RA = 4'd3; RB = 4'd5; RC = 4'd6;
      #1;
      chk("pre_rst_a", A, 32'hDEADBEEF);
      chk("pre_rst_b", B, 32'h55);
      chk("pre_rst_cbusy", {31'd0, CBUSY}, 32'h1);
      chk("pre_rst_pc", PC, 32'h4);
      #2 CLR = 1'b0;
      #1;
      chk("arst_a", A, 32'h0);
      chk("arst_b", B, 32'h0);
      chk("arst_c", C, 32'h0);
      chk("arst_pc", PC, 32'h0);
      chk("arst_busy", {29'd0, ABUSY, BBUSY, CBUSY}, 32'h0);
      RC = 4'd15;
      #1;
      chk("arst_c_pc", C, 32'h8);
      WE = 1'b1; WA = 4'd3; WD = 32'h123; PCINC = 1'b1;
      #1;
      chk("arst_nobyp", A, 32'h0);
      tick();
      chk("arst_hold_a", A, 32'h0);
      chk("arst_hold_pc", PC, 32'h0);
      CLR = 1'b1;
      #1;
      chk("post_rst_byp", A, 32'h123);
      chk("post_rst_nb", nb_a, 32'h0);
      tick();
      idle();
      #1;
      chk("post_rst_wr", nb_a, 32'h123);
      chk("post_rst_pc", PC, 32'h4);
      chk("post_rst_c", C, 32'hC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
